// File: rtl/hack_data_mem_if.sv
// hack_data_mem_if: the Hack CPU data port.
//   addressM : 15-bit data address        (CPU -> memory)
//   outM     : 16-bit write data          (CPU -> memory)
//   writeM   : write strobe               (CPU -> memory)
//   inM      : 16-bit read data, combinational (memory -> CPU)
interface hack_data_mem_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;

  modport master (output addressM, output outM, output writeM, input inM);
  modport slave  (input addressM, input outM, input writeM, output inM);
endinterface

// File: rtl/hack_data_mem.sv
// hack_data_mem: data-memory responder for the Hack CPU.
//   Maps the CPU data port onto RAM (0x0000..RAM_WORDS-1), a screen buffer
//   (0x4000..0x4000+SCREEN_WORDS-1), a keyboard FIFO (0x6000, write pops)
//   and a free-running 16-bit timer (0x6001, write loads).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   bus        CPU data port (slave side); inM is combinational
//   scr_addr   display read address
//   scr_data   screen word at scr_addr, registered, 1-cycle latency
//   key_valid  key producer has a code
//   key_code   scan code (never 0)
//   key_ready  FIFO not full
//   bus_err    sticky: an unmapped address was presented to the CPU port
// Parameter limits: RAM_WORDS <= 16384, SCREEN_WORDS <= 8192,
// KBD_DEPTH a power of two and >= 2.
module hack_data_mem #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  hack_data_mem_if.slave     bus,
  input  logic [12:0]        scr_addr,
  output logic [15:0]        scr_data,
  input  logic               key_valid,
  input  logic [15:0]        key_code,
  output logic               key_ready,
  output logic               bus_err
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int SCR_AW = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
  localparam int KP     = $clog2(KBD_DEPTH);

  localparam logic [15:0] RAM_END  = 16'(RAM_WORDS);
  localparam logic [15:0] SCR_BASE = 16'h4000;
  localparam logic [15:0] SCR_END  = 16'h4000 + 16'(SCREEN_WORDS);
  localparam logic [15:0] KBD_ADDR = 16'h6000;
  localparam logic [15:0] TMR_ADDR = 16'h6001;
  localparam logic [KP:0] KBD_FULL = (KP + 1)'(KBD_DEPTH);

  // storage
  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCREEN_WORDS];
  logic [15:0] r_kbd [KBD_DEPTH];

  logic [KP-1:0] r_head;
  logic [KP-1:0] r_tail;
  logic [KP:0]   r_count;
  logic [15:0]   r_timer;
  logic [15:0]   r_scr_data;
  logic          r_bus_err;

  // decode
  logic [15:0]       w_addr16;
  logic              w_sel_ram;
  logic              w_sel_scr;
  logic              w_sel_kbd;
  logic              w_sel_tmr;
  logic              w_unmapped;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;
  logic [SCR_AW-1:0] w_disp_idx;
  logic              w_disp_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [15:0]       w_in_m;

  assign w_addr16   = {1'b0, bus.addressM};
  assign w_sel_ram  = (w_addr16 < RAM_END);
  assign w_sel_scr  = (w_addr16 >= SCR_BASE) && (w_addr16 < SCR_END);
  assign w_sel_kbd  = (w_addr16 == KBD_ADDR);
  assign w_sel_tmr  = (w_addr16 == TMR_ADDR);
  assign w_unmapped = !(w_sel_ram || w_sel_scr || w_sel_kbd || w_sel_tmr);

  assign w_ram_idx  = bus.addressM[RAM_AW-1:0];
  // The screen base is 0x4000 and the window is at most 8K words, so the
  // low address bits are already the offset into the buffer.
  assign w_scr_idx  = bus.addressM[SCR_AW-1:0];
  assign w_disp_idx = scr_addr[SCR_AW-1:0];

  generate
    if (SCREEN_WORDS < 8192) begin : g_scr_lim
      localparam logic [13:0] SCR_LIM = 14'(SCREEN_WORDS);
      assign w_disp_ok = ({1'b0, scr_addr} < SCR_LIM);
    end else begin : g_scr_full
      assign w_disp_ok = 1'b1;
    end
  endgenerate

  assign w_full    = (r_count == KBD_FULL);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push    = key_valid && !w_full;
  assign w_pop     = bus.writeM && w_sel_kbd && (r_count != '0);

  // CPU read path
  always_comb begin
    w_in_m = 16'h0000;
    if (w_sel_ram) begin
      w_in_m = r_ram[w_ram_idx];
    end else if (w_sel_scr) begin
      w_in_m = r_scr[w_scr_idx];
    end else if (w_sel_kbd) begin
      if (r_count != '0) w_in_m = r_kbd[r_head];
    end else if (w_sel_tmr) begin
      w_in_m = r_timer;
    end
  end

  assign bus.inM   = w_in_m;
  assign scr_data  = r_scr_data;
  assign key_ready = !w_full;
  assign bus_err   = r_bus_err;

  // Memory arrays are left out of reset so they map onto RAM macros; writes
  // are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && bus.writeM && w_sel_ram) r_ram[w_ram_idx] <= bus.outM;
    if (reset && bus.writeM && w_sel_scr) r_scr[w_scr_idx] <= bus.outM;
    if (reset && w_push)                  r_kbd[r_tail]    <= key_code;
  end

  // Display read port: reads the pre-write word on a same-cycle collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scr_data <= 16'h0000;
    end else if (w_disp_ok) begin
      r_scr_data <= r_scr[w_disp_idx];
    end else begin
      r_scr_data <= 16'h0000;
    end
  end

  // Key FIFO control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Timer: a CPU load wins over the increment for that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= 16'h0000;
    end else if (bus.writeM && w_sel_tmr) begin
      r_timer <= bus.outM;
    end else begin
      r_timer <= r_timer + 16'h0001;
    end
  end

  // Every cycle the CPU presents an unmapped address counts, read or write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else if (w_unmapped) begin
      r_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_data_mem.sv
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        key_valid;
  logic [15:0] key_code;
  logic        key_ready;
  logic        bus_err;

  hack_data_mem_if bus();

  hack_data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram   [16384];
  bit          m_ram_v [16384];
  logic [15:0] m_scr   [8192];
  bit          m_scr_v [8192];
  logic [15:0] m_q[$];
  logic [15:0] m_t;
  bit          m_err;
  logic [15:0] m_sd;
  bit          m_sd_v;

  task automatic model_reset();
    m_q.delete();
    m_t    = 16'h0000;
    m_err  = 1'b0;
    m_sd   = 16'h0000;
    m_sd_v = 1'b1;
  endtask

  task automatic model_step();
    int a;
    int ps;
    bit push;
    bit pop;
    a    = int'(bus.addressM);
    ps   = m_q.size();
    push = key_valid && (ps < 4);
    pop  = bus.writeM && (a == 'h6000) && (ps > 0);
    m_sd   = m_scr[scr_addr];
    m_sd_v = m_scr_v[scr_addr];
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(key_code);
    if (bus.writeM && a < 'h4000) begin
      m_ram[a] = bus.outM; m_ram_v[a] = 1'b1;
    end else if (bus.writeM && a < 'h6000) begin
      m_scr[a - 'h4000] = bus.outM; m_scr_v[a - 'h4000] = 1'b1;
    end
    if (bus.writeM && a == 'h6001) m_t = bus.outM;
    else                           m_t = m_t + 16'h0001;
    if (a > 'h6001) m_err = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  task automatic exp_inm(input int a, output logic [15:0] e, output bit v);
    v = 1'b1;
    e = 16'h0000;
    if (a < 'h4000) begin
      e = m_ram[a]; v = m_ram_v[a];
    end else if (a < 'h6000) begin
      e = m_scr[a - 'h4000]; v = m_scr_v[a - 'h4000];
    end else if (a == 'h6000) begin
      if (m_q.size() > 0) e = m_q[0];
    end else if (a == 'h6001) begin
      e = m_t;
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] e;
    bit v;
    exp_inm(int'(bus.addressM), e, v);
    if (v) cmp("inM", bus.inM, e);
    cmp("key_ready", 16'(key_ready), 16'(m_q.size() < 4));
    cmp("bus_err", 16'(bus_err), 16'(m_err));
    if (m_sd_v) cmp("scr_data", scr_data, m_sd);
  endtask

  task automatic drv(input logic [14:0] a, input logic [15:0] d, input logic w);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = w;
  endtask

  task automatic half(); @(negedge clk); check_model(); endtask
  task automatic fin();  @(posedge clk); #1; endtask
  task automatic tick(); half(); fin(); endtask

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drv(15'h6000, 16'h0000, 1'b0);
    scr_addr  = 13'd0;
    key_valid = 1'b0;
    key_code  = 16'h0000;
    #1 reset = 1'b0;

    repeat (3) tick();
    half();
    cmp("rst_key_ready", 16'(key_ready), 16'h0001);
    cmp("rst_bus_err",   16'(bus_err),   16'h0000);
    cmp("rst_scr_data",  scr_data,       16'h0000);
    cmp("rst_kbd",       bus.inM,        16'h0000);
    drv(15'h6001, 16'h0000, 1'b0);
    #1 cmp("rst_timer", bus.inM, 16'h0000);
    fin();

    // timer counts from reset release
    reset = 1'b1;
    repeat (10) tick();
    half(); cmp("timer_10", bus.inM, 16'd10); fin();

    // RAM
    drv(15'd0, 16'h1234, 1'b1); tick();
    drv(15'd1, 16'h000F, 1'b1); tick();
    drv(15'd1, 16'h0000, 1'b0);
    half(); cmp("ram1", bus.inM, 16'h000F); fin();
    drv(15'd0, 16'h0000, 1'b0);
    half(); cmp("ram0_kept", bus.inM, 16'h1234); cmp("ram_bus_err", 16'(bus_err), 16'h0000); fin();
    drv(15'd1, 16'h7777, 1'b1);
    half(); cmp("ram_wr_old", bus.inM, 16'h000F); fin();
    drv(15'd1, 16'h000F, 1'b1); tick();

    // screen
    drv(15'h4005, 16'hABCD, 1'b1); tick();
    scr_addr = 13'd5;
    drv(15'h4005, 16'h5555, 1'b1); tick();
    drv(15'h4005, 16'h0000, 1'b0);
    half(); cmp("scr_old", scr_data, 16'hABCD); cmp("scr_cpu_rd", bus.inM, 16'h5555); fin();
    half(); cmp("scr_new", scr_data, 16'h5555); fin();

    // keyboard FIFO
    drv(15'h6000, 16'h0000, 1'b0);
    key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_code = 16'(16'h0041 + i);
      tick();
    end
    key_code = 16'h0045;
    half(); cmp("kbd_full", 16'(key_ready), 16'h0000); cmp("kbd_head", bus.inM, 16'h0041); fin();
    drv(15'h6000, 16'hFFFF, 1'b1); tick();  // pop while full: 0x45 still refused
    key_valid = 1'b0;
    drv(15'h6000, 16'h0000, 1'b0);
    half(); cmp("kbd_pop1", bus.inM, 16'h0042); cmp("kbd_ready", 16'(key_ready), 16'h0001); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_pop2", bus.inM, 16'h0043); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_pop3", bus.inM, 16'h0044); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_empty", bus.inM, 16'h0000); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0);
    half(); cmp("kbd_extra_pop", bus.inM, 16'h0000); cmp("kbd_extra_rdy", 16'(key_ready), 16'h0001); fin();
    key_valid = 1'b1;
    key_code = 16'h0051; tick();
    key_code = 16'h0052; tick();
    key_code = 16'h0053;
    drv(15'h6000, 16'h0000, 1'b1); tick();  // push + pop at count 2
    key_valid = 1'b0;
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_pp_head", bus.inM, 16'h0052); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_pp_tail", bus.inM, 16'h0053); fin();
    drv(15'h6000, 16'h0000, 1'b1); tick();
    drv(15'h6000, 16'h0000, 1'b0); half(); cmp("kbd_pp_empty", bus.inM, 16'h0000); fin();

    // timer load and wrap
    drv(15'h6001, 16'hFFFE, 1'b1); tick();
    drv(15'h6001, 16'h0000, 1'b0);
    half(); cmp("tmr_load", bus.inM, 16'hFFFE); fin();
    half(); cmp("tmr_ffff", bus.inM, 16'hFFFF); fin();
    half(); cmp("tmr_wrap", bus.inM, 16'h0000); fin();

    // unmapped
    drv(15'h7000, 16'h0000, 1'b0);
    half(); cmp("unm_rd", bus.inM, 16'h0000); fin();
    drv(15'd1, 16'h0000, 1'b0);
    half(); cmp("unm_err", 16'(bus_err), 16'h0001); cmp("unm_ram", bus.inM, 16'h000F); fin();
    drv(15'd0, 16'h4321, 1'b1); tick();
    drv(15'd0, 16'h0000, 1'b0);
    half(); cmp("unm_sticky", 16'(bus_err), 16'h0001); fin();

    // asynchronous reset mid-cycle
    key_valid = 1'b1;
    key_code = 16'h0061; tick();
    key_code = 16'h0062; tick();
    key_valid = 1'b0;
    drv(15'h6001, 16'h0123, 1'b1); tick();
    drv(15'h6001, 16'h0000, 1'b0);
    #1 cmp("pre_rst_timer", bus.inM, 16'h0123);
    #1 reset = 1'b0;
    #1 cmp("arst_timer", bus.inM, 16'h0000);
    cmp("arst_ready", 16'(key_ready), 16'h0001);
    cmp("arst_scr", scr_data, 16'h0000);
    cmp("arst_err", 16'(bus_err), 16'h0000);
    drv(15'h6000, 16'h0000, 1'b0);
    #1 cmp("arst_kbd", bus.inM, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    drv(15'd1, 16'h0000, 1'b0);
    half(); cmp("arst_ram_kept", bus.inM, 16'h000F); fin();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [14:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 15'($urandom_range(0, 15));
        4, 5:       a = 15'(16'h4000 + 16'($urandom_range(0, 15)));
        6:          a = 15'h6000;
        7:          a = 15'h6001;
        8:          a = ($urandom_range(0, 3) == 0) ? 15'($urandom_range('h6002, 'h7FFF)) : 15'h6000;
        default:    a = 15'($urandom_range(0, 'h7FFF));
      endcase
      drv(a, 16'($urandom), 1'($urandom_range(0, 1)));
      scr_addr  = 13'($urandom_range(0, 15));
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 16'($urandom_range(1, 'hFFFF));
      reset     = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
